dcache_refill: RTL and testbench
================================

Name: dcache_refill

Overview:
Line refill/writeback sequencer for the 4-way data cache. It sits directly upstream of the data-cache data RAM and owns its write port: index, way, offset, din, we and en. On a miss it optionally writes the dirty victim line back to memory, fetches the new line word-by-word and writes each word into the selected way. It reports completion to the cache controller.

Parameters:
dw, 32, data word width (matches data RAM)
iw, `D_INDEX_WIDTH, set index width
ow, `D_WO_WIDTH, word-offset width; words per line = 2^ow
tw, 32-iw-ow-2, tag width; byte address = {tag, index, offset, 2'b00}

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  miss request
req_ready  out  1  high only in IDLE
req_index  in  iw  set index
req_way  in  2  victim way
req_dirty  in  1  victim line needs writeback
req_victim_tag  in  tw  victim line tag
req_fill_tag  in  tw  new line tag
ram_index  out  iw  data RAM index
ram_way  out  2  data RAM way
ram_offset  out  ow  data RAM word offset
ram_din  out  dw  data RAM write data
ram_we  out  1  data RAM write enable
ram_en  out  1  data RAM enable
ram_dout0..ram_dout3  in  dw each  data RAM per-way read data (combinational)
mem_cmd_valid  out  1  line command valid
mem_cmd_ready  in  1  memory accepts command
mem_cmd_we  out  1  1 = line write, 0 = line read
mem_cmd_addr  out  32  line base byte address, low ow+2 bits zero
mem_wdata  out  dw  writeback word
mem_wvalid  out  1  writeback word valid
mem_wready  in  1  memory accepts writeback word
mem_rdata  in  dw  fill word
mem_rvalid  in  1  fill word valid, one word per cycle, no backpressure
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_n=0): state=IDLE, word counter cnt=0. All registered outputs are 0: ram_*, mem_cmd_*, mem_wvalid, done, busy. req_ready=1. Reset mid-operation abandons the transfer with no further RAM write.
- States are IDLE, WB_CMD, WB_DATA, FILL_CMD, FILL_DATA, DONE.
- IDLE: on req_valid&req_ready, latch index, way, dirty and both tags.
  - Go to WB_CMD if dirty, else FILL_CMD.
  - ram_index and ram_way take the latched values and hold them until the next request.
- WB_CMD: mem_cmd_valid=1, mem_cmd_we=1, mem_cmd_addr={victim_tag,index,ow'b0,2'b00}.
  - On mem_cmd_ready go to WB_DATA with cnt=0, ram_offset=0, ram_en=1, ram_we=0.
- WB_DATA: mem_wvalid=1.
  - mem_wdata = ram_dout[ram_way], combinational mux.
  - On mem_wready: cnt++, ram_offset<=cnt+1.
  - When cnt==2^ow-1 and mem_wready: go to FILL_CMD, ram_en<=0.
  - mem_wdata must stay stable while wvalid&!wready.
- FILL_CMD: mem_cmd_valid=1, mem_cmd_we=0, mem_cmd_addr={fill_tag,index,0}.
  - On mem_cmd_ready go to FILL_DATA with cnt=0.
- FILL_DATA: on each mem_rvalid, on the next cycle ram_din=rdata, ram_offset=cnt, ram_we=1, ram_en=1, for exactly one cycle per word; cnt++.
  - rvalid on the last word (cnt==2^ow-1) moves to DONE.
  - rvalid outside FILL_DATA is ignored.
- DONE: carries the final word's RAM write. done=1 for one cycle, then IDLE.
- Data RAM writes land on the negedge of the cycle in which ram_we is asserted, so each word is written half a cycle after its registered outputs are presented.
- ram_we is never asserted in WB_DATA. ram_we=0 whenever ram_en=0.
- cnt wraps only via state exit and never overflows into the next line.
- mem_cmd_valid, once asserted, holds with stable addr/we until ready.
- Latency with zero-wait memory (ready=1, rvalid back-to-back, 4 words per line):
  - clean miss: 6 cycles from request acceptance to done;
  - dirty miss: 11 cycles.

Test Plan:
- Bench configuration for all scenarios: iw=4, ow=2 (4 words per line).
- Reset: rst_n low mid-clock -> outputs 0 and req_ready=1 immediately; the rst_n deassert is glitch-free.
- Clean miss: index=3, way=2, fill_tag=0x1234, rdata 0xA0..0xA3 back-to-back -> one read cmd at addr {0x1234,3,0}; way2 offsets 0..3 hold A0..A3; done 6 cycles after accept.
- Dirty miss: way1 preloaded 0x11..0x14, victim_tag=0x55 -> write cmd at {0x55,idx,0}; mem_wdata sequence 0x11..0x14; then fill completes and way1 holds the fill data; other ways are unchanged.
- Backpressure: mem_cmd_ready low 3 cycles, mem_wready toggling 1/0 -> cmd and addr stable while stalled; wdata held during stalls; no word skipped or duplicated.
- Gapped fill: rvalid at cycles 0, 2, 5, 6 -> exactly 4 single-cycle ram_we pulses at offsets 0..3; done after the 4th word.
- Reset mid-fill after 2 words -> no further ram_we; a new request afterwards completes normally.

Source files
------------

// File: rtl/dcache_refill_if.sv
// dcache_refill_if: miss request, data-RAM write port and line-memory bus of the refill sequencer.
`ifndef D_INDEX_WIDTH
`define D_INDEX_WIDTH 4
`endif
`ifndef D_WO_WIDTH
`define D_WO_WIDTH 2
`endif
interface dcache_refill_if #(
    parameter int dw = 32,
    parameter int iw = `D_INDEX_WIDTH,
    parameter int ow = `D_WO_WIDTH
);
    localparam int tw = 32 - iw - ow - 2;
    logic          req_valid;
    logic          req_ready;
    logic [iw-1:0] req_index;
    logic [1:0]    req_way;
    logic          req_dirty;
    logic [tw-1:0] req_victim_tag;
    logic [tw-1:0] req_fill_tag;
    logic [iw-1:0] ram_index;
    logic [1:0]    ram_way;
    logic [ow-1:0] ram_offset;
    logic [dw-1:0] ram_din;
    logic          ram_we;
    logic          ram_en;
    logic [dw-1:0] ram_dout0;
    logic [dw-1:0] ram_dout1;
    logic [dw-1:0] ram_dout2;
    logic [dw-1:0] ram_dout3;
    logic          mem_cmd_valid;
    logic          mem_cmd_ready;
    logic          mem_cmd_we;
    logic [31:0]   mem_cmd_addr;
    logic [dw-1:0] mem_wdata;
    logic          mem_wvalid;
    logic          mem_wready;
    logic [dw-1:0] mem_rdata;
    logic          mem_rvalid;
    logic          busy;
    logic          done;
    modport master (
        input  req_valid, req_index, req_way, req_dirty, req_victim_tag, req_fill_tag,
        input  ram_dout0, ram_dout1, ram_dout2, ram_dout3,
        input  mem_cmd_ready, mem_wready, mem_rdata, mem_rvalid,
        output req_ready, ram_index, ram_way, ram_offset, ram_din, ram_we, ram_en,
        output mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata, mem_wvalid, busy, done
    );
    modport slave (
        output req_valid, req_index, req_way, req_dirty, req_victim_tag, req_fill_tag,
        output ram_dout0, ram_dout1, ram_dout2, ram_dout3,
        output mem_cmd_ready, mem_wready, mem_rdata, mem_rvalid,
        input  req_ready, ram_index, ram_way, ram_offset, ram_din, ram_we, ram_en,
        input  mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata, mem_wvalid, busy, done
    );
endinterface

// File: rtl/dcache_refill.sv
// dcache_refill: writes back a dirty victim line, fetches the new line and writes it into the
// selected way of the data RAM, owning the RAM write port throughout.
`ifndef D_INDEX_WIDTH
`define D_INDEX_WIDTH 4
`endif
`ifndef D_WO_WIDTH
`define D_WO_WIDTH 2
`endif
module dcache_refill #(
    parameter int dw = 32,
    parameter int iw = `D_INDEX_WIDTH,
    parameter int ow = `D_WO_WIDTH
) (
    input logic              clk,
    input logic              rst_n,
    dcache_refill_if.master  bus
);
    localparam int tw = 32 - iw - ow - 2;
    localparam logic [ow-1:0] last = '1;

    typedef enum logic [2:0] {IDLE, WB_CMD, WB_DATA, FILL_CMD, FILL_DATA, DONE} state_t;

    state_t        state, state_n;
    logic [ow-1:0] cnt, cnt_n;
    logic [tw-1:0] vtag, vtag_n, ftag, ftag_n;
    logic [iw-1:0] index_n;
    logic [1:0]    way_n;
    logic [ow-1:0] offset_n;
    logic [dw-1:0] din_n;
    logic          we_n, en_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            vtag           <= '0;
            ftag           <= '0;
            bus.ram_index  <= '0;
            bus.ram_way    <= '0;
            bus.ram_offset <= '0;
            bus.ram_din    <= '0;
            bus.ram_we     <= 1'b0;
            bus.ram_en     <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            vtag           <= vtag_n;
            ftag           <= ftag_n;
            bus.ram_index  <= index_n;
            bus.ram_way    <= way_n;
            bus.ram_offset <= offset_n;
            bus.ram_din    <= din_n;
            bus.ram_we     <= we_n;
            bus.ram_en     <= en_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        vtag_n   = vtag;
        ftag_n   = ftag;
        index_n  = bus.ram_index;
        way_n    = bus.ram_way;
        offset_n = bus.ram_offset;
        din_n    = bus.ram_din;
        we_n     = 1'b0;
        en_n     = 1'b0;
        case (state)
            IDLE: if (bus.req_valid) begin
                state_n = bus.req_dirty ? WB_CMD : FILL_CMD;
                index_n = bus.req_index;
                way_n   = bus.req_way;
                vtag_n  = bus.req_victim_tag;
                ftag_n  = bus.req_fill_tag;
            end
            WB_CMD: if (bus.mem_cmd_ready) begin
                state_n  = WB_DATA;
                cnt_n    = '0;
                offset_n = '0;
                en_n     = 1'b1;
            end
            // RAM read stays enabled; the offset only advances once memory takes the word
            WB_DATA: begin
                en_n = 1'b1;
                if (bus.mem_wready) begin
                    cnt_n    = cnt + 1'b1;
                    offset_n = cnt + 1'b1;
                    if (cnt == last) begin
                        state_n = FILL_CMD;
                        en_n    = 1'b0;
                    end
                end
            end
            FILL_CMD: if (bus.mem_cmd_ready) begin
                state_n = FILL_DATA;
                cnt_n   = '0;
            end
            FILL_DATA: if (bus.mem_rvalid) begin
                we_n     = 1'b1;
                en_n     = 1'b1;
                din_n    = bus.mem_rdata;
                offset_n = cnt;
                cnt_n    = cnt + 1'b1;
                if (cnt == last) state_n = DONE;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.req_ready     = state == IDLE;
    assign bus.busy          = state != IDLE;
    assign bus.done          = state == DONE;
    assign bus.mem_cmd_valid = state == WB_CMD || state == FILL_CMD;
    assign bus.mem_cmd_we    = state == WB_CMD;
    assign bus.mem_cmd_addr  = state == WB_CMD   ? {vtag, bus.ram_index, {(ow + 2){1'b0}}} :
                               state == FILL_CMD ? {ftag, bus.ram_index, {(ow + 2){1'b0}}} : 32'd0;
    assign bus.mem_wvalid    = state == WB_DATA;
    assign bus.mem_wdata     = !bus.mem_wvalid     ? '0 :
                               bus.ram_way == 2'd0 ? bus.ram_dout0 :
                               bus.ram_way == 2'd1 ? bus.ram_dout1 :
                               bus.ram_way == 2'd2 ? bus.ram_dout2 : bus.ram_dout3;
endmodule

// File: tb/tb_dcache_refill.sv
// tb_dcache_refill: directed miss scenarios against a queue-based model of the refill sequencer
// and a behavioural 4-way data RAM.
module tb_dcache_refill;
    localparam int DW = 32, IW = 4, OW = 2, TW = 32 - IW - OW - 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dcache_refill_if #(.dw(DW), .iw(IW), .ow(OW)) bus();
    dcache_refill #(.dw(DW), .iw(IW), .ow(OW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

    logic [DW-1:0] ram     [4][16][4];
    logic [DW-1:0] exp_ram [4][16][4];
    logic [32:0]   ecmd_q[$];
    logic [31:0]   ewd_q[$];
    logic [39:0]   ewr_q[$];
    logic [31:0]   wlog[$];
    logic [31:0]   last_wr, last_rd;
    logic [IW-1:0] cur_idx;
    logic [1:0]    cur_way;
    logic          prev_done = 1'b0;
    int            npass = 0, nchk = 0, nwe = 0;

    assign bus.ram_dout0 = ram[0][bus.ram_index][bus.ram_offset];
    assign bus.ram_dout1 = ram[1][bus.ram_index][bus.ram_offset];
    assign bus.ram_dout2 = ram[2][bus.ram_index][bus.ram_offset];
    assign bus.ram_dout3 = ram[3][bus.ram_index][bus.ram_offset];

    always @(negedge clk)
        if (bus.ram_we && bus.ram_en) ram[bus.ram_way][bus.ram_index][bus.ram_offset] <= bus.ram_din;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.busy) begin
                chk("ram_index", 64'(bus.ram_index), 64'(cur_idx));
                chk("ram_way", 64'(bus.ram_way), 64'(cur_way));
            end
            if (bus.mem_cmd_valid) begin
                if (ecmd_q.size() == 0) chk("cmd_unexpected", 64'd1, 64'd0);
                else begin
                    chk("cmd", 64'({bus.mem_cmd_we, bus.mem_cmd_addr}), 64'(ecmd_q[0]));
                    if (bus.mem_cmd_ready) void'(ecmd_q.pop_front());
                end
            end
            if (bus.mem_wvalid) begin
                if (ewd_q.size() == 0) chk("wdata_unexpected", 64'd1, 64'd0);
                else begin
                    chk("wdata", 64'(bus.mem_wdata), 64'(ewd_q[0]));
                    if (bus.mem_wready) begin
                        wlog.push_back(bus.mem_wdata);
                        void'(ewd_q.pop_front());
                    end
                end
            end
            if (bus.ram_we) begin
                nwe <= nwe + 1;
                chk("we_implies_en", 64'(bus.ram_en), 64'd1);
                if (ewr_q.size() == 0) chk("ram_we_unexpected", 64'd1, 64'd0);
                else chk("ram_write", 64'({bus.ram_way, bus.ram_index, bus.ram_offset, bus.ram_din}),
                         64'(ewr_q.pop_front()));
            end
            if (bus.done) begin
                chk("done_single", 64'(prev_done), 64'd0);
                chk("done_drained", 64'(ecmd_q.size() + ewd_q.size() + ewr_q.size()), 64'd0);
            end
            prev_done <= bus.done;
        end else prev_done <= 1'b0;
    end

    task automatic check_reset();
        chk("rst_ram_ctl", 64'({bus.ram_index, bus.ram_way, bus.ram_offset, bus.ram_we, bus.ram_en}), 64'd0);
        chk("rst_ram_din", 64'(bus.ram_din), 64'd0);
        chk("rst_cmd", 64'({bus.mem_cmd_valid, bus.mem_cmd_we, bus.mem_cmd_addr}), 64'd0);
        chk("rst_misc", 64'({bus.mem_wvalid, bus.done, bus.busy}), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    endtask

    task automatic check_line(input logic [IW-1:0] idx);
        for (int wy = 0; wy < 4; wy++)
            for (int k = 0; k < 4; k++)
                chk($sformatf("line_i%0d_w%0d_o%0d", idx, wy, k), 64'(ram[wy][idx][k]), 64'(exp_ram[wy][idx][k]));
    endtask

    // Drives one miss; the model queues the commands, writeback words and RAM writes it implies.
    task automatic run_miss(input logic [IW-1:0] idx, input logic [1:0] way, input logic dirty,
                            input logic [TW-1:0] vtag, input logic [TW-1:0] ftag, input logic [31:0] base,
                            input int stall, input bit toggle, input logic [7:0] gap, input bit noise,
                            input int abort_w, output int lat);
        int st, f, w;
        bit filling, start_fill, ph;
        lat = -1; st = stall; f = 0; w = 0; filling = 0; start_fill = 0; ph = 1;
        cur_idx = idx; cur_way = way;
        if (dirty) begin
            ecmd_q.push_back({1'b1, vtag, idx, 4'b0000});
            for (int k = 0; k < 4; k++) ewd_q.push_back(exp_ram[way][idx][k]);
        end
        ecmd_q.push_back({1'b0, ftag, idx, 4'b0000});
        bus.req_valid = 1'b1; bus.req_index = idx; bus.req_way = way; bus.req_dirty = dirty;
        bus.req_victim_tag = vtag; bus.req_fill_tag = ftag;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (bus.done) begin
                lat = c;
                break;
            end
            if (abort_w > 0 && w == abort_w) begin
                bus.mem_rvalid = 1'b0; bus.mem_cmd_ready = 1'b0; bus.mem_wready = 1'b0;
                #6 rst_n = 1'b0;
                #1 check_reset();
                chk("abort_drained", 64'(ecmd_q.size() + ewd_q.size() + ewr_q.size()), 64'd0);
                ecmd_q.delete(); ewd_q.delete(); ewr_q.delete();
                return;
            end
            if (start_fill) filling = 1;
            start_fill = 0;
            bus.mem_cmd_ready = 1'b0;
            if (bus.mem_cmd_valid) begin
                if (st > 0) st--;
                else begin
                    bus.mem_cmd_ready = 1'b1;
                    if (bus.mem_cmd_we) last_wr = bus.mem_cmd_addr;
                    else begin
                        last_rd = bus.mem_cmd_addr;
                        start_fill = 1;
                    end
                    st = stall;
                end
            end
            bus.mem_wready = bus.mem_wvalid && (!toggle || ph);
            ph = !ph;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata = 32'hDEAD_BEEF;
            if (filling && w < 4) begin
                if (gap[f]) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata = base + w;
                    ewr_q.push_back({way, idx, 2'(w), base + w});
                    exp_ram[way][idx][w] = base + w;
                    w++;
                end
                f++;
            end else if (noise) bus.mem_rvalid = 1'b1;
            @(posedge clk); #1;
        end
        bus.mem_cmd_ready = 1'b0; bus.mem_wready = 1'b0; bus.mem_rvalid = 1'b0;
        chk("done_seen", 64'(lat > 0), 64'd1);
    endtask

    initial begin
        int lat, n0;
        bus.req_valid = 0; bus.req_index = '0; bus.req_way = '0; bus.req_dirty = 0;
        bus.req_victim_tag = '0; bus.req_fill_tag = '0;
        bus.mem_cmd_ready = 0; bus.mem_wready = 0; bus.mem_rdata = '0; bus.mem_rvalid = 0;
        for (int wy = 0; wy < 4; wy++)
            for (int i = 0; i < 16; i++)
                for (int k = 0; k < 4; k++) begin
                    ram[wy][i][k] = 32'h0F00_0000 | (wy << 12) | (i << 4) | k;
                    exp_ram[wy][i][k] = ram[wy][i][k];
                end
        for (int k = 0; k < 4; k++) begin
            ram[1][5][k] = 32'h11 + k;
            exp_ram[1][5][k] = 32'h11 + k;
        end

        #2 rst_n = 1'b0;
        #1 check_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // fill data outside a refill must not reach the RAM
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0;
        repeat (2) begin @(posedge clk); #1; end
        bus.mem_rvalid = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_write", 64'(nwe), 64'd0);
        chk("idle_ready", 64'(bus.req_ready), 64'd1);

        run_miss(4'd3, 2'd2, 1'b0, '0, 24'h001234, 32'hA0, 0, 0, 8'h0F, 0, 0, lat);
        chk("clean_latency", 64'(lat), 64'd6);
        chk("clean_rd_addr", 64'(last_rd), 64'h0012_3430);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) chk("clean_way2", 64'(ram[2][3][k]), 64'(32'hA0 + k));
        check_line(4'd3);

        wlog.delete();
        run_miss(4'd5, 2'd1, 1'b1, 24'h000055, 24'h000077, 32'hB0, 0, 0, 8'h0F, 0, 0, lat);
        chk("dirty_latency", 64'(lat), 64'd11);
        chk("dirty_wr_addr", 64'(last_wr), 64'h0000_5550);
        chk("dirty_rd_addr", 64'(last_rd), 64'h0000_7750);
        chk("dirty_wcount", 64'(wlog.size()), 64'd4);
        for (int k = 0; k < 4 && k < wlog.size(); k++) chk("dirty_wdata", 64'(wlog[k]), 64'(32'h11 + k));
        @(posedge clk); #1;
        chk("dirty_way1_w0", 64'(ram[1][5][0]), 64'hB0);
        check_line(4'd5);

        wlog.delete();
        run_miss(4'd7, 2'd3, 1'b1, 24'h000ABC, 24'h000DEF, 32'hC0, 3, 1, 8'h0F, 1, 0, lat);
        chk("bp_wcount", 64'(wlog.size()), 64'd4);
        chk("bp_rd_addr", 64'(last_rd), 64'h000D_EF70);
        @(posedge clk); #1;
        check_line(4'd7);

        n0 = nwe;
        run_miss(4'd9, 2'd0, 1'b0, '0, 24'h000042, 32'hD0, 0, 0, 8'h65, 0, 0, lat);
        chk("gap_latency", 64'(lat), 64'd9);
        @(posedge clk); #1;
        chk("gap_we_pulses", 64'(nwe - n0), 64'd4);
        check_line(4'd9);

        n0 = nwe;
        run_miss(4'd11, 2'd2, 1'b0, '0, 24'h000099, 32'hE0, 0, 0, 8'h0F, 0, 2, lat);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        chk("abort_we_pulses", 64'(nwe - n0), 64'd2);
        chk("abort_w2", 64'(ram[2][11][2]), 64'(exp_ram[2][11][2]));
        check_line(4'd11);
        run_miss(4'd11, 2'd2, 1'b0, '0, 24'h000099, 32'hF0, 0, 0, 8'h0F, 0, 0, lat);
        chk("after_abort_latency", 64'(lat), 64'd6);
        @(posedge clk); #1;
        check_line(4'd11);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
